// File: rtl/rename_alloc_nw.sv
// rename_alloc_nw
//   N-wide register rename and ROB-id allocation stage between decode and
//   dispatch. Each source register is renamed to "read ARF" (pend=0) or
//   "wait on ROB entry robid" (pend=1). Accepted groups get consecutive ROB
//   ids, occupancy is tracked exactly against retirement, and a flush
//   recovers in one cycle.
//
// Ports
//   clk, rst_n          clock, synchronous active-low reset
//   in_valid_i/ready_o  decode group handshake
//   in_inst_valid_i     per-slot valid
//   in_rarid_i          two source ARF ids per slot ({slot1.s1, slot1.s0, slot0.s1, slot0.s0})
//   in_warid_i          destination ARF id per slot, 0 = no write
//   out_valid_o/ready_i renamed group handshake (registered)
//   out_inst_valid_o    registered slot valids
//   out_rrobid_o        producer ROB id per source
//   out_rpend_o         1 = wait on out_rrobid_o, 0 = read ARF
//   out_wrobid_o        allocated ROB id per slot (0 for invalid slots)
//   retire_*            per-slot retire strobes, oldest first
//   flush_i             squash everything in flight
//   flush_ack_o         one-cycle pulse after a flush
module rename_alloc_nw #(
  parameter int WIDTH     = 2,
  parameter int ROB_DEPTH = 64,
  parameter int ARF_DEPTH = 32,
  parameter int ROBW      = $clog2(ROB_DEPTH),
  parameter int ARFW      = $clog2(ARF_DEPTH)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid_i,
  output logic                      in_ready_o,
  input  logic [WIDTH-1:0]          in_inst_valid_i,
  input  logic [WIDTH*2*ARFW-1:0]   in_rarid_i,
  input  logic [WIDTH*ARFW-1:0]     in_warid_i,
  output logic                      out_valid_o,
  input  logic                      out_ready_i,
  output logic [WIDTH-1:0]          out_inst_valid_o,
  output logic [WIDTH*2*ROBW-1:0]   out_rrobid_o,
  output logic [WIDTH*2-1:0]        out_rpend_o,
  output logic [WIDTH*ROBW-1:0]     out_wrobid_o,
  input  logic [WIDTH-1:0]          retire_i,
  input  logic [WIDTH-1:0]          retire_wen_i,
  input  logic [WIDTH*ARFW-1:0]     retire_arfid_i,
  input  logic [WIDTH*ROBW-1:0]     retire_robid_i,
  input  logic                      flush_i,
  output logic                      flush_ack_o
);

  // Register alias table: pend marks an uncommitted youngest writer.
  logic [ARF_DEPTH-1:0] rat_pend;
  logic [ROBW-1:0]      rat_robid     [ARF_DEPTH];
  logic [ARF_DEPTH-1:0] rat_pend_nxt;
  logic [ROBW-1:0]      rat_robid_nxt [ARF_DEPTH];

  logic [ROBW-1:0]      tail;
  logic [ROBW:0]        count;

  logic                 accept;
  logic [ROBW:0]        free_cnt;
  logic [ROBW:0]        alloc_cnt;
  logic [ROBW:0]        retire_cnt;
  logic [ROBW-1:0]      slot_id [WIDTH];
  logic [WIDTH-1:0]     ret_clr;
  logic [WIDTH*ROBW-1:0]   wrobid;
  logic [WIDTH*2-1:0]      src_pend;
  logic [WIDTH*2*ROBW-1:0] src_robid;
  logic [ARFW-1:0]      src_id;
  logic                 grp_hit;
  logic [ROBW-1:0]      grp_id;

  // Occupancy uses the registered count only; same-cycle retires do not
  // open space until the next cycle.
  always_comb begin
    free_cnt   = (ROBW+1)'(ROB_DEPTH) - count;
    in_ready_o = !flush_i && (free_cnt >= (ROBW+1)'(WIDTH)) &&
                 (!out_valid_o || out_ready_i);
  end

  assign accept = in_valid_i && in_ready_o;

  // ROB id allocation, compacted over invalid slots.
  always_comb begin
    alloc_cnt = '0;
    wrobid    = '0;
    for (int unsigned j = 0; j < WIDTH; j++) begin
      slot_id[j] = tail + alloc_cnt[ROBW-1:0];
      if (in_inst_valid_i[j]) begin
        wrobid[j*ROBW +: ROBW] = slot_id[j];
        alloc_cnt = alloc_cnt + (ROBW+1)'(1);
      end
    end
  end

  // Retires that may clear a RAT entry; ignored entirely during flush.
  always_comb begin
    retire_cnt = '0;
    ret_clr    = '0;
    for (int unsigned k = 0; k < WIDTH; k++) begin
      ret_clr[k] = retire_i[k] && retire_wen_i[k] && !flush_i &&
                   (retire_arfid_i[k*ARFW +: ARFW] != '0);
      if (retire_i[k]) retire_cnt = retire_cnt + (ROBW+1)'(1);
    end
  end

  // Source rename: r0, then intra-group bypass (youngest older slot), then
  // the RAT with same-cycle retire clears forwarded.
  always_comb begin
    src_pend  = '0;
    src_robid = '0;
    src_id    = '0;
    grp_hit   = 1'b0;
    grp_id    = '0;
    for (int unsigned j = 0; j < WIDTH; j++) begin
      for (int unsigned s = 0; s < 2; s++) begin
        src_id  = in_rarid_i[(j*2+s)*ARFW +: ARFW];
        grp_hit = 1'b0;
        grp_id  = '0;
        for (int unsigned k = 0; k < j; k++) begin
          if (in_inst_valid_i[k] && (in_warid_i[k*ARFW +: ARFW] == src_id)) begin
            grp_hit = 1'b1;
            grp_id  = slot_id[k];
          end
        end
        if (src_id == '0) begin
          src_pend[j*2+s]               = 1'b0;
          src_robid[(j*2+s)*ROBW +: ROBW] = '0;
        end else if (grp_hit) begin
          src_pend[j*2+s]               = 1'b1;
          src_robid[(j*2+s)*ROBW +: ROBW] = grp_id;
        end else begin
          src_pend[j*2+s]               = rat_pend[src_id];
          src_robid[(j*2+s)*ROBW +: ROBW] = rat_robid[src_id];
          for (int unsigned k = 0; k < WIDTH; k++) begin
            if (ret_clr[k] && (retire_arfid_i[k*ARFW +: ARFW] == src_id) &&
                (retire_robid_i[k*ROBW +: ROBW] == rat_robid[src_id]))
              src_pend[j*2+s] = 1'b0;
          end
        end
      end
    end
  end

  // RAT next state: retire clears first, then rename writes so that a
  // same-cycle rename overrides the clear and the youngest slot wins.
  always_comb begin
    rat_pend_nxt  = rat_pend;
    rat_robid_nxt = rat_robid;
    if (flush_i) begin
      rat_pend_nxt = '0;
    end else begin
      for (int unsigned k = 0; k < WIDTH; k++) begin
        if (ret_clr[k] && rat_pend[retire_arfid_i[k*ARFW +: ARFW]] &&
            (rat_robid[retire_arfid_i[k*ARFW +: ARFW]] == retire_robid_i[k*ROBW +: ROBW]))
          rat_pend_nxt[retire_arfid_i[k*ARFW +: ARFW]] = 1'b0;
      end
      if (accept) begin
        for (int unsigned j = 0; j < WIDTH; j++) begin
          if (in_inst_valid_i[j] && (in_warid_i[j*ARFW +: ARFW] != '0)) begin
            rat_pend_nxt[in_warid_i[j*ARFW +: ARFW]]  = 1'b1;
            rat_robid_nxt[in_warid_i[j*ARFW +: ARFW]] = slot_id[j];
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rat_pend         <= '0;
      rat_robid        <= '{default: '0};
      tail             <= '0;
      count            <= '0;
      out_valid_o      <= 1'b0;
      out_inst_valid_o <= '0;
      out_rrobid_o     <= '0;
      out_rpend_o      <= '0;
      out_wrobid_o     <= '0;
      flush_ack_o      <= 1'b0;
    end else begin
      rat_pend    <= rat_pend_nxt;
      rat_robid   <= rat_robid_nxt;
      flush_ack_o <= flush_i;
      if (flush_i) begin
        tail        <= '0;
        count       <= '0;
        out_valid_o <= 1'b0;
      end else begin
        count <= count + (accept ? alloc_cnt : '0) - retire_cnt;
        if (accept) begin
          tail             <= tail + alloc_cnt[ROBW-1:0];
          out_valid_o      <= 1'b1;
          out_inst_valid_o <= in_inst_valid_i;
          out_rrobid_o     <= src_robid;
          out_rpend_o      <= src_pend;
          out_wrobid_o     <= wrobid;
        end else if (out_ready_i) begin
          out_valid_o <= 1'b0;
        end
      end
    end
  end

  // Retiring more than is in flight is a protocol error.
  always_ff @(posedge clk) begin
    if (rst_n && !flush_i) begin
      retire_underflow: assert (retire_cnt <= count);
    end
  end

endmodule

// File: tb/tb_rename_alloc_nw.sv
module tb_rename_alloc_nw;
  localparam int W = 2, RD = 8, AD = 32, RW = 3, AW = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid_i, in_ready_o, out_valid_o, out_ready_i, flush_i, flush_ack_o;
  logic [W-1:0]      in_inst_valid_i, out_inst_valid_o;
  logic [W*2*AW-1:0] in_rarid_i;
  logic [W*AW-1:0]   in_warid_i;
  logic [W*2*RW-1:0] out_rrobid_o;
  logic [W*2-1:0]    out_rpend_o;
  logic [W*RW-1:0]   out_wrobid_o;
  logic [W-1:0]      retire_i, retire_wen_i;
  logic [W*AW-1:0]   retire_arfid_i;
  logic [W*RW-1:0]   retire_robid_i;

  rename_alloc_nw #(.WIDTH(W), .ROB_DEPTH(RD), .ARF_DEPTH(AD)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .in_inst_valid_i(in_inst_valid_i), .in_rarid_i(in_rarid_i), .in_warid_i(in_warid_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .out_inst_valid_o(out_inst_valid_o), .out_rrobid_o(out_rrobid_o),
    .out_rpend_o(out_rpend_o), .out_wrobid_o(out_wrobid_o),
    .retire_i(retire_i), .retire_wen_i(retire_wen_i),
    .retire_arfid_i(retire_arfid_i), .retire_robid_i(retire_robid_i),
    .flush_i(flush_i), .flush_ack_o(flush_ack_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic             v;
    logic [1:0]       iv;
    logic [3:0][4:0]  src;   // index = slot*2 + source
    logic [1:0][4:0]  dst;
    logic             rdy;
    logic [1:0][2:0]  wid;
    logic [3:0]       pend;
    logic [3:0][2:0]  rid;
  } vec_t;

  typedef struct {
    logic [2:0] id;
    logic [4:0] dst;
  } ent_t;

  int checks = 0;
  int failures = 0;
  vec_t tbl[5];
  vec_t g, gi, gx, rv, m_exp;
  ent_t q[$];
  logic [2:0] mtail;
  logic m_ov, m_ack, exp_rdy;
  int nret;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [1:0] iv, input logic [3:0][4:0] src,
                              input logic [1:0][4:0] dst, input logic rdy,
                              input logic [1:0][2:0] wid, input logic [3:0] pend,
                              input logic [3:0][2:0] rid);
    vec_t e;
    e.v = 1'b1; e.iv = iv; e.src = src; e.dst = dst; e.rdy = rdy;
    e.wid = wid; e.pend = pend; e.rid = rid;
    return e;
  endfunction

  task automatic drive(input vec_t e);
    in_valid_i = e.v;
    in_inst_valid_i = e.iv;
    in_rarid_i = e.src;
    in_warid_i = e.dst;
  endtask

  task automatic set_ret(input logic [1:0] r, input logic [1:0] wen,
                         input logic [1:0][4:0] arf, input logic [1:0][2:0] rid);
    retire_i = r; retire_wen_i = wen; retire_arfid_i = arf; retire_robid_i = rid;
  endtask

  task automatic chk_group(input string tag, input vec_t e);
    chk({tag, ".out_valid"}, 32'(out_valid_o), 32'd1);
    chk({tag, ".inst_valid"}, 32'(out_inst_valid_o), 32'(e.iv));
    for (int j = 0; j < 2; j++)
      chk($sformatf("%s.wrobid%0d", tag, j), 32'(out_wrobid_o[j*RW +: RW]),
          e.iv[j] ? 32'(e.wid[j]) : 32'd0);
    for (int i = 0; i < 4; i++) begin
      if (e.iv[i/2]) begin
        chk($sformatf("%s.rpend%0d", tag, i), 32'(out_rpend_o[i]), 32'(e.pend[i]));
        if (e.pend[i] || e.src[i] == 5'd0)
          chk($sformatf("%s.rrobid%0d", tag, i), 32'(out_rrobid_o[i*RW +: RW]),
              (e.src[i] == 5'd0) ? 32'd0 : 32'(e.rid[i]));
      end
    end
  endtask

  initial begin
    in_valid_i = 0; in_inst_valid_i = '0; in_rarid_i = '0; in_warid_i = '0;
    out_ready_i = 1; flush_i = 0;
    set_ret(2'b00, 2'b00, '0, '0);

    // Dependency / WAW / fill-to-full vectors, starting from reset (tail 0).
    tbl[0] = mk(2'b11, {5'd0, 5'd1, 5'd3, 5'd2}, {5'd2, 5'd1}, 1, {3'd1, 3'd0},
                4'b0100, {3'd0, 3'd0, 3'd0, 3'd0});
    tbl[1] = mk(2'b11, {5'd0, 5'd0, 5'd2, 5'd1}, {5'd0, 5'd0}, 1, {3'd3, 3'd2},
                4'b0011, {3'd0, 3'd0, 3'd1, 3'd0});
    tbl[2] = mk(2'b11, {5'd0, 5'd0, 5'd0, 5'd0}, {5'd5, 5'd5}, 1, {3'd5, 3'd4},
                4'b0000, '0);
    tbl[3] = mk(2'b11, {5'd5, 5'd2, 5'd1, 5'd5}, {5'd0, 5'd0}, 1, {3'd7, 3'd6},
                4'b1111, {3'd5, 3'd1, 3'd0, 3'd5});
    tbl[4] = mk(2'b11, '0, '0, 0, '0, '0, '0);

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst.out_valid", 32'(out_valid_o), 0);
    chk("rst.flush_ack", 32'(flush_ack_o), 0);
    chk("rst.inst_valid", 32'(out_inst_valid_o), 0);
    chk("rst.wrobid", 32'(out_wrobid_o), 0);
    chk("rst.rpend", 32'(out_rpend_o), 0);
    chk("rst.rrobid", 32'(out_rrobid_o), 0);
    chk("rst.in_ready", 32'(in_ready_o), 1);
    rst_n = 1;

    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i > 0 && tbl[i-1].rdy) chk_group($sformatf("tbl%0d", i-1), tbl[i-1]);
      drive(tbl[i]);
      #1 chk($sformatf("tbl%0d.in_ready", i), 32'(in_ready_o), 32'(tbl[i].rdy));
    end

    // Full ROB: retire one (count 7, stalled), then another (reopens next cycle).
    @(negedge clk); set_ret(2'b01, 2'b01, {5'd0, 5'd1}, {3'd0, 3'd0});
    #1 chk("full.ready_ret1", 32'(in_ready_o), 0);
    @(negedge clk); set_ret(2'b00, 2'b00, '0, '0);
    #1 chk("full.ready_cnt7", 32'(in_ready_o), 0);
    @(negedge clk); set_ret(2'b01, 2'b01, {5'd0, 5'd2}, {3'd0, 3'd1});
    #1 chk("full.ready_ret2_same", 32'(in_ready_o), 0);
    @(negedge clk); set_ret(2'b00, 2'b00, '0, '0);
    g = mk(2'b11, {5'd0, 5'd5, 5'd2, 5'd1}, {5'd3, 5'd4}, 1, {3'd1, 3'd0},
           4'b0100, {3'd0, 3'd5, 3'd0, 3'd0});
    drive(g);
    #1 chk("full.ready_reopen", 32'(in_ready_o), 1);

    // Flush
    @(negedge clk); chk_group("wrap", g);
    flush_i = 1;
    #1 chk("flush.ready", 32'(in_ready_o), 0);
    @(negedge clk);
    chk("flush.ack", 32'(flush_ack_o), 1);
    chk("flush.out_valid", 32'(out_valid_o), 0);
    flush_i = 0;
    g = mk(2'b11, {5'd1, 5'd3, 5'd5, 5'd4}, {5'd3, 5'd4}, 1, {3'd1, 3'd0}, 4'b0000, '0);
    drive(g);
    #1 chk("flush.ready_after", 32'(in_ready_o), 1);

    // Retire forwarding vs read, then retire vs rename write.
    @(negedge clk); chk_group("post_flush", g);
    chk("flush.ack_clear", 32'(flush_ack_o), 0);
    set_ret(2'b01, 2'b01, {5'd0, 5'd4}, {3'd0, 3'd0});
    g = mk(2'b11, {5'd0, 5'd0, 5'd3, 5'd4}, {5'd0, 5'd0}, 1, {3'd3, 3'd2},
           4'b0010, {3'd0, 3'd0, 3'd1, 3'd0});
    drive(g);
    @(negedge clk); chk_group("ret_fwd", g);
    set_ret(2'b01, 2'b01, {5'd0, 5'd3}, {3'd0, 3'd1});
    g = mk(2'b11, '0, {5'd0, 5'd3}, 1, {3'd5, 3'd4}, 4'b0000, '0);
    drive(g);
    @(negedge clk); chk_group("ret_vs_wr", g);
    set_ret(2'b00, 2'b00, '0, '0);
    gi = mk(2'b11, {5'd0, 5'd0, 5'd4, 5'd3}, {5'd0, 5'd7}, 1, {3'd7, 3'd6},
            4'b0001, {3'd0, 3'd0, 3'd0, 3'd4});
    drive(gi);

    // Backpressure for three cycles
    @(negedge clk); chk_group("ret_vs_wr_read", gi);
    out_ready_i = 0;
    gx = mk(2'b01, {5'd0, 5'd0, 5'd0, 5'd7}, '0, 1, {3'd0, 3'd0},
            4'b0001, {3'd0, 3'd0, 3'd0, 3'd6});
    drive(gx);
    #1 chk("bp.ready0", 32'(in_ready_o), 0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); chk_group($sformatf("bp.hold%0d", c), gi);
      if (c == 2) out_ready_i = 1;
      #1 chk($sformatf("bp.ready%0d", c + 1), 32'(in_ready_o), (c == 2) ? 32'd1 : 32'd0);
    end
    @(negedge clk); chk_group("bp.release", gx);
    in_valid_i = 0;
    flush_i = 1;
    @(negedge clk);
    chk("rflush.ack", 32'(flush_ack_o), 1);
    flush_i = 0;

    // Randomized phase against a queue-based model of in-flight instructions.
    q.delete(); mtail = '0; m_ov = 0; m_ack = 0;
    m_exp = mk('0, '0, '0, 0, '0, '0, '0);
    for (int cyc = 0; cyc < 2000; cyc++) begin
      flush_i = ($urandom_range(0, 24) == 0);
      out_ready_i = ($urandom_range(0, 3) != 0);
      rv.v = ($urandom_range(0, 3) != 0);
      rv.iv = 2'($urandom_range(0, 3));
      for (int i = 0; i < 4; i++) rv.src[i] = 5'($urandom_range(0, 7));
      for (int j = 0; j < 2; j++) rv.dst[j] = 5'($urandom_range(0, 7));
      drive(rv);
      nret = $urandom_range(0, (q.size() < 2) ? q.size() : 2);
      set_ret(2'b00, 2'b00, '0, '0);
      for (int l = 0; l < nret; l++) begin
        retire_i[l] = 1'b1;
        retire_wen_i[l] = (q[l].dst != 5'd0);
        retire_arfid_i[l*AW +: AW] = q[l].dst;
        retire_robid_i[l*RW +: RW] = q[l].id;
      end
      #1;
      exp_rdy = !flush_i && ((RD - q.size()) >= W) && (!m_ov || out_ready_i);
      chk("rnd.in_ready", 32'(in_ready_o), 32'(exp_rdy));
      m_ack = flush_i;
      if (flush_i) begin
        q.delete(); mtail = '0; m_ov = 0;
      end else begin
        for (int l = 0; l < nret; l++) q.delete(0);
        if (rv.v && exp_rdy) begin
          m_exp = rv;
          m_exp.wid = '0;
          for (int j = 0, a = 0; j < 2; j++)
            if (rv.iv[j]) begin m_exp.wid[j] = mtail + 3'(a); a++; end
          for (int i = 0; i < 4; i++) begin
            logic found;
            logic [2:0] id;
            found = 0; id = '0;
            if (rv.src[i] != 5'd0) begin
              for (int k = 0; k < i / 2; k++)
                if (rv.iv[k] && rv.dst[k] == rv.src[i]) begin found = 1; id = m_exp.wid[k]; end
              if (!found)
                for (int e = q.size() - 1; e >= 0; e--)
                  if (!found && q[e].dst == rv.src[i]) begin found = 1; id = q[e].id; end
            end
            m_exp.pend[i] = found;
            m_exp.rid[i] = id;
          end
          for (int j = 0; j < 2; j++)
            if (rv.iv[j]) begin
              ent_t ne;
              ne.id = m_exp.wid[j]; ne.dst = rv.dst[j];
              q.push_back(ne);
              mtail = mtail + 3'd1;
            end
          m_ov = 1;
        end else if (out_ready_i) begin
          m_ov = 0;
        end
      end
      @(negedge clk);
      chk("rnd.out_valid", 32'(out_valid_o), 32'(m_ov));
      chk("rnd.flush_ack", 32'(flush_ack_o), 32'(m_ack));
      if (m_ov) chk_group("rnd", m_exp);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
